seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider. It computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor using restoring shift-subtract, retiring one quotient bit per clock.
- It is the inverse-arithmetic companion to the team's ripple-carry add datapath and reuses the same subtract-and-carry structure in a sequential loop.
- It sits behind a valid/ready request channel and a valid/ready result channel, so it drops into a pipeline stage that stalls on long-latency ops.

---
 rtl/seq_restoring_divider.sv | 176 +++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle restoring shift-subtract divider.
//
// Retires one quotient bit per clock behind a valid/ready request channel
// and a valid/ready result channel. Unsigned by default; define
// SEQ_DIVIDER_SIGNED_EN for two's-complement operands (magnitudes go
// through the unsigned core, then a SIGN state applies the result signs).
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE.
// The result holds steady while out_valid && !out_ready. A result retiring
// and a new request being accepted never share a cycle.
//
// The FSM state is kept in the 'state' signal of type state_t so checkers
// can observe it directly.

module seq_restoring_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd3
  } state_t;
`endif

  state_t state;

  // Working registers: div_q starts as the dividend and shifts quotient
  // bits in from the right; div_r is the partial remainder. Because the
  // partial remainder is always below the divisor after each step, WIDTH
  // bits hold it; the WIDTH+1-bit trial value covers the shifted-in bit.
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;
  logic [WIDTH-1:0] div_d;
  logic [CW-1:0]    iter;
  logic             zero_div;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             q_neg;
  logic             r_neg;
`endif

  // One restoring step: shift in the next dividend bit, try a subtract.
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;

  // Trial subtract; the borrow out of the WIDTH+1-bit subtract decides the bit.
  always_comb begin
    trial  = {div_r, div_q[WIDTH-1]};
    diff   = trial - {1'b0, div_d};
    take   = ~diff[WIDTH];
    r_next = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    q_next = {div_q[WIDTH-2:0], take};
  end

`ifdef SEQ_DIVIDER_SIGNED_EN
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    // MIN maps to itself, which is its correct unsigned magnitude.
    return v[WIDTH-1] ? (~v + 1'b1) : v;
  endfunction
`endif

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  // Divider FSM: capture, iterate, optional sign fix-up, hold result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      div_q       <= '0;
      div_r       <= '0;
      div_d       <= '0;
      iter        <= '0;
      zero_div    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            iter     <= '0;
            div_r    <= '0;
            zero_div <= (divisor == '0);
`ifdef SEQ_DIVIDER_SIGNED_EN
            div_d    <= magnitude(divisor);
            // A zero divisor reports the raw dividend, so keep it unmodified.
            div_q    <= (divisor == '0) ? dividend : magnitude(dividend);
            q_neg    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_neg    <= dividend[WIDTH-1];
`else
            div_d    <= divisor;
            div_q    <= dividend;
`endif
            state    <= S_CALC;
          end
        end

        S_CALC: begin
          if (zero_div) begin
            quotient    <= '1;
            remainder   <= div_q;
            div_by_zero <= 1'b1;
            state       <= S_DONE;
          end else begin
            div_r <= r_next;
            div_q <= q_next;
            iter  <= iter + 1'b1;
            if (iter == LAST_ITER) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
              state       <= S_SIGN;
`else
              quotient    <= q_next;
              remainder   <= r_next;
              div_by_zero <= 1'b0;
              state       <= S_DONE;
`endif
            end
          end
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        S_SIGN: begin
          // Quotient truncates toward zero; remainder follows the dividend.
          quotient    <= q_neg ? (~div_q + 1'b1) : div_q;
          remainder   <= r_neg ? (~div_r + 1'b1) : div_r;
          div_by_zero <= 1'b0;
          state       <= S_DONE;
        end
`endif

        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: directed and random checks of the sequential
// divider against a plain-arithmetic reference model. Build with
// +define+SEQ_DIVIDER_SIGNED_EN to exercise the signed variant.

module tb_seq_restoring_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};
  localparam int WAIT_LIMIT = W + 20;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_checks;
  int n_fail;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results and edges from handshake to out_valid.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat);
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
      lat = 1;
    end else begin
      z = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (a == MIN_VAL && b == '1) begin
        q = MIN_VAL;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
      lat = W + 1;
`else
      q = a / b;
      r = a % b;
      lat = W;
`endif
    end
  endtask

  // Full transaction: request, wait for result, optional back-pressure, retire.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    int           elat;
    int           lat;
    model(a, b, eq, er, ez, elat);

    check("in_ready_before_req", W'(in_ready), W'(1));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    check("in_ready_after_req", W'(in_ready), W'(0));

    lat = 0;
    while (!out_valid && lat < WAIT_LIMIT) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), W'(elat));
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_by_zero", W'(div_by_zero), W'(ez));

    for (int i = 0; i < hold; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      dividend  = $urandom;
      divisor   = $urandom;
      out_ready = 1'b0;
      @(posedge clk); #1;
      check("hold_valid", W'(out_valid), W'(1));
      check("hold_in_ready", W'(in_ready), W'(0));
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
    end

    out_ready = 1'b1;
    in_valid  = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    check("retire_valid", W'(out_valid), W'(0));
    check("retire_in_ready", W'(in_ready), W'(1));
    check("retire_keeps_quotient", quotient, eq);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", W'(in_ready), W'(1));
    check("idle_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    dividend  = 32'd55;
    divisor   = 32'd5;

    // Reset: requests presented during reset must not be captured.
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", W'(in_ready), W'(1));
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_quotient", quotient, '0);
    check("rst_remainder", remainder, '0);
    check("rst_dbz", W'(div_by_zero), W'(0));
    in_valid = 1'b0;
    rst      = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", W'(in_ready), W'(1));

    // Directed cases
    run_op(32'd100, 32'd7, 0);
    run_op(32'hFFFF_FFFF, 32'd1, 0);
    run_op(32'd3, 32'd10, 1);
    run_op(32'h1234_5678, 32'd0, 0);
    run_op(32'd1000, 32'd33, 5);
    run_op(32'd77, 32'd77, 0);
    run_op(32'd0, 32'd9, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);

    // Reset partway through an operation abandons it.
    in_valid = 1'b1;
    dividend = 32'd500;
    divisor  = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", W'(out_valid), W'(0));
    check("abort_quotient", quotient, '0);
    check("abort_remainder", remainder, '0);
    check("abort_dbz", W'(div_by_zero), W'(0));
    check("abort_in_ready", W'(in_ready), W'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_still_idle", W'(out_valid), W'(0));
    run_op(32'd9, 32'd4, 0);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op(-32'sd7, 32'sd2, 0);
    run_op(MIN_VAL, '1, 1);
    run_op(32'sd7, -32'sd2, 0);
    run_op(-32'sd100, -32'sd7, 0);
    run_op(-32'sd5, 32'd0, 0);
`endif

    // Random operations, biased toward small divisors and edge values.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = W'($urandom_range(0, 20));
        1: rb = ra;
        2: rb = ra + W'($urandom_range(1, 50));
        3: rb = W'($urandom_range(1, 65535));
        default: rb = $urandom;
      endcase
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
